sw_result_collector: RTL and testbench

SW_RESULT_COLLECTOR -- requirements
Module: sw_result_collector

---
 rtl/sw_result_collector.sv | 142 ++++++++++++++
 tb/tb_sw_result_collector.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/sw_result_collector.sv
// Collects Smith-Waterman results from the last PE and queues {score, len, id} in a 4-entry FIFO.
// Latency: a result captured at one edge is visible on the outputs after that edge.
// Backpressure: out_ready stalls the head entry; a capture into a full FIFO with no pop is dropped and flagged.
module sw_result_collector #(
  parameter int SCORE_WIDTH = 12,
  parameter int ZERO        = 2**(SCORE_WIDTH-1),
  parameter int ID_WIDTH    = 8,
  parameter int LEN_WIDTH   = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en_in,
  input  logic                   vld_in,
  input  logic [SCORE_WIDTH-1:0] High_in,
  input  logic                   out_ready,
  output logic                   out_valid,
  output logic [SCORE_WIDTH-1:0] score_out,
  output logic [LEN_WIDTH-1:0]   len_out,
  output logic [ID_WIDTH-1:0]    id_out,
  output logic                   overflow,
  output logic                   proto_err
);

  typedef enum logic [2:0] {
    IDLE  = 3'b001,
    BURST = 3'b010,
    DONE  = 3'b100
  } state_t;

  typedef struct packed {
    logic [SCORE_WIDTH-1:0] score;
    logic [LEN_WIDTH-1:0]   len;
    logic [ID_WIDTH-1:0]    id;
  } entry_t;

  localparam logic [SCORE_WIDTH-1:0] ZERO_V = SCORE_WIDTH'(ZERO);

  state_t                 state_q, state_d;
  logic [LEN_WIDTH-1:0]   len_q, len_d;
  logic [ID_WIDTH-1:0]    id_q;
  logic                   capture, perr_set;
  logic [SCORE_WIDTH-1:0] diff, score_c;

  entry_t                 mem_q [4];
  logic [1:0]             wr_ptr_q, rd_ptr_q;
  logic [2:0]             count_q;
  logic                   ovf_q, perr_q;
  logic                   full, pop, push, drop;
  entry_t                 head;

  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    capture  = 1'b0;
    perr_set = 1'b0;
    case (state_q)
      IDLE: begin
        perr_set = vld_in;
        if (en_in) begin
          state_d = BURST;
          len_d   = LEN_WIDTH'(1);
        end
      end
      BURST: begin
        perr_set = vld_in;
        if (en_in) begin
          if (len_q != '1) len_d = len_q + LEN_WIDTH'(1);
        end else begin
          state_d = DONE;
        end
      end
      DONE: begin
        // The result strobe is only legal in the cycle right after the burst ends.
        capture  = vld_in;
        perr_set = !vld_in;
        if (en_in) begin
          state_d = BURST;
          len_d   = LEN_WIDTH'(1);
        end else begin
          state_d = IDLE;
          len_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        len_d   = '0;
      end
    endcase
  end

  assign diff = High_in - ZERO_V;

  always_comb begin
    score_c = (High_in >= ZERO_V) ? diff : '0;
    score_c[SCORE_WIDTH-1] = 1'b0;
  end

  assign full = (count_q == 3'd4);
  assign pop  = out_valid && out_ready;
  assign push = capture && (!full || pop);
  assign drop = capture && full && !pop;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      len_q    <= '0;
      id_q     <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      perr_q   <= 1'b0;
      for (int i = 0; i < 4; i++) mem_q[i] <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      // Dropped captures still consume an id so the gap is visible downstream.
      if (capture) id_q <= id_q + ID_WIDTH'(1);
      if (push) begin
        mem_q[wr_ptr_q] <= '{score: score_c, len: len_q, id: id_q};
        wr_ptr_q        <= wr_ptr_q + 2'd1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 2'd1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 3'd1;
        2'b01:   count_q <= count_q - 3'd1;
        default: count_q <= count_q;
      endcase
      if (drop)     ovf_q  <= 1'b1;
      if (perr_set) perr_q <= 1'b1;
    end
  end

  assign head      = mem_q[rd_ptr_q];
  assign out_valid = (count_q != 3'd0);
  assign score_out = head.score;
  assign len_out   = head.len;
  assign id_out    = head.id;
  assign overflow  = ovf_q;
  assign proto_err = perr_q;

endmodule

// File: tb/tb_sw_result_collector.sv
// Bench for sw_result_collector: directed scenarios then random traffic, scored against a queue model.
module tb_sw_result_collector;
  localparam int SW   = 12;
  localparam int IW   = 8;
  localparam int LW   = 16;
  localparam int ZERO = 2048;

  logic          clk = 1'b0;
  logic          rst, en_in, vld_in, out_ready;
  logic [SW-1:0] High_in;
  logic          out_valid, overflow, proto_err;
  logic [SW-1:0] score_out;
  logic [LW-1:0] len_out;
  logic [IW-1:0] id_out;

  sw_result_collector #(.SCORE_WIDTH(SW), .ZERO(ZERO), .ID_WIDTH(IW), .LEN_WIDTH(LW)) dut (
    .clk(clk), .rst(rst), .en_in(en_in), .vld_in(vld_in), .High_in(High_in),
    .out_ready(out_ready), .out_valid(out_valid), .score_out(score_out),
    .len_out(len_out), .id_out(id_out), .overflow(overflow), .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  typedef struct {int score; int len; int id;} ent_t;
  ent_t q[$];
  bit   m_active, m_window, m_ovf, m_perr, m_rst;
  int   m_len, m_id;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  // Reference behaviour: a burst of en cycles sets the length, the cycle after it ends is the result window.
  task automatic model_step(input bit e, input bit v, input int h, input bit r, input bit rs);
    bit do_pop, cap;
    int len_before;
    if (!rs) begin
      q.delete();
      m_active = 0; m_window = 0; m_len = 0; m_id = 0;
      m_ovf = 0; m_perr = 0; m_rst = 1;
      return;
    end
    m_rst      = 0;
    do_pop     = (q.size() > 0) && r;
    cap        = 0;
    len_before = m_len;
    if (m_window) begin
      if (v) cap = 1; else m_perr = 1;
      m_window = 0;
      m_active = e;
      m_len    = e ? 1 : 0;
    end else begin
      if (v) m_perr = 1;
      if (e) begin
        m_len    = m_active ? ((m_len < 65535) ? m_len + 1 : 65535) : 1;
        m_active = 1;
      end else if (m_active) begin
        m_active = 0;
        m_window = 1;
      end
    end
    if (do_pop) void'(q.pop_front());
    if (cap) begin
      if (q.size() == 4) m_ovf = 1;
      else q.push_back('{score: (h >= ZERO) ? h - ZERO : 0, len: len_before, id: m_id});
      m_id = (m_id + 1) % 256;
    end
  endtask

  task automatic compare_all();
    chk("out_valid", out_valid, q.size() > 0);
    chk("overflow", overflow, m_ovf);
    chk("proto_err", proto_err, m_perr);
    if (q.size() > 0) begin
      chk("score_out", score_out, q[0].score);
      chk("len_out", len_out, q[0].len);
      chk("id_out", id_out, q[0].id);
    end else if (m_rst) begin
      chk("rst_score", score_out, 0);
      chk("rst_len", len_out, 0);
      chk("rst_id", id_out, 0);
    end
  endtask

  task automatic cyc(input bit e, input bit v, input int h, input bit r, input bit rs);
    en_in = e; vld_in = v; High_in = h[SW-1:0]; out_ready = r; rst = rs;
    @(posedge clk);
    model_step(e, v, h, r, rs);
    #1;
    compare_all();
  endtask

  task automatic do_reset();
    cyc(0, 0, 0, 0, 0);
  endtask

  initial begin
    do_reset();
    do_reset();
    chk("reset_valid", out_valid, 0);
    chk("reset_ovf", overflow, 0);
    chk("reset_perr", proto_err, 0);

    // Five-cycle burst, then the result one cycle after en drops.
    for (int i = 0; i < 5; i++) cyc(1, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 1);
    cyc(0, 1, ZERO + 23, 0, 1);
    chk("b5_valid", out_valid, 1);
    chk("b5_score", score_out, 23);
    chk("b5_len", len_out, 5);
    chk("b5_id", id_out, 0);
    cyc(0, 0, 0, 1, 1);

    // Negative biased score clamps to zero.
    cyc(1, 0, 0, 0, 1);
    cyc(1, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 1);
    cyc(0, 1, ZERO - 4, 0, 1);
    chk("neg_score", score_out, 0);
    chk("neg_len", len_out, 2);
    cyc(0, 0, 0, 1, 1);

    // Six captures into a stalled FIFO, then drain.
    do_reset();
    cyc(1, 0, 0, 0, 1);
    for (int i = 0; i < 6; i++) begin
      cyc(0, 0, 0, 0, 1);
      cyc(1, 1, ZERO + 10 * i, 0, 1);
    end
    chk("six_ovf", overflow, 1);
    chk("six_head", id_out, 0);
    for (int i = 0; i < 4; i++) begin
      chk("drain_id", id_out, i);
      cyc(0, 0, 0, 1, 1);
    end
    chk("drain_empty", out_valid, 0);
    cyc(1, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 1);
    cyc(0, 1, ZERO + 1, 0, 1);
    chk("id_after_drop", id_out, 6);

    // Full FIFO with simultaneous pop and push.
    do_reset();
    cyc(1, 0, 0, 0, 1);
    for (int i = 0; i < 4; i++) begin
      cyc(0, 0, 0, 0, 1);
      cyc(1, 1, ZERO + i, 0, 1);
    end
    cyc(0, 0, 0, 0, 1);
    cyc(0, 1, ZERO + 99, 1, 1);
    chk("full_pp_ovf", overflow, 0);
    chk("full_pp_head", id_out, 1);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1, 1);
    chk("full_pp_tail_id", id_out, 4);
    chk("full_pp_tail_score", score_out, 99);

    // Stray strobe in IDLE, then capture coinciding with a new burst.
    do_reset();
    cyc(0, 1, ZERO + 5, 0, 1);
    chk("idle_vld_perr", proto_err, 1);
    chk("idle_vld_valid", out_valid, 0);
    for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 1);
    cyc(1, 1, ZERO + 7, 0, 1);
    chk("restart_first_len", len_out, 3);
    cyc(0, 0, 0, 1, 1);
    cyc(0, 1, ZERO + 8, 1, 1);
    chk("restart_len", len_out, 1);

    // Reset mid-burst with three entries queued.
    do_reset();
    cyc(0, 1, 0, 0, 1);
    cyc(1, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 0, 0, 1);
      cyc(1, 1, ZERO + i, 0, 1);
    end
    cyc(1, 0, 0, 0, 0);
    chk("midrst_valid", out_valid, 0);
    chk("midrst_ovf", overflow, 0);
    chk("midrst_perr", proto_err, 0);
    cyc(1, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 1);
    cyc(0, 1, ZERO + 3, 0, 1);
    chk("midrst_id", id_out, 0);
    chk("midrst_len", len_out, 1);

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      bit e, v, r, rs;
      int h;
      e  = ($urandom_range(0, 2) != 0);
      v  = m_window ? ($urandom_range(0, 4) != 0) : ($urandom_range(0, 24) == 0);
      r  = ($urandom_range(0, 2) == 0);
      rs = ($urandom_range(0, 149) != 0);
      h  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 4095))
                                       : int'($urandom_range(ZERO - 40, ZERO + 300));
      cyc(e, v, h, r, rs);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
